// File: rtl/rg_scoreboard_if.sv
// Decode/writeback bundle for rg_scoreboard: two read ports, one writeback port,
// one reserve port, plus the scoreboard status outputs.
interface rg_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              rd1_en_i;
    logic [ADDR_W-1:0] rd1_addr_i;
    logic [DATA_W-1:0] rd1_data_o;
    logic              rd1_ready_o;
    logic              rd2_en_i;
    logic [ADDR_W-1:0] rd2_addr_i;
    logic [DATA_W-1:0] rd2_data_o;
    logic              rd2_ready_o;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rsv_en_i;
    logic [ADDR_W-1:0] rsv_addr_i;
    logic              rsv_ack_o;
    logic [ADDR_W:0]   busy_count_o;
    logic              err_o;

    modport master (
        output rd1_en_i, rd1_addr_i, rd2_en_i, rd2_addr_i,
        output wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        input  rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o,
        input  rsv_ack_o, busy_count_o, err_o
    );

    modport slave (
        input  rd1_en_i, rd1_addr_i, rd2_en_i, rd2_addr_i,
        input  wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        output rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o,
        output rsv_ack_o, busy_count_o, err_o
    );
endinterface

// File: rtl/rg_scoreboard.sv
// 2-read/1-write register file with write bypass and a per-register pending
// scoreboard so decode can stall on RAW hazards against in-flight writebacks.
module rg_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rg_scoreboard_if.slave bus
);
    localparam int REG_NUM = 1 << ADDR_W;

    logic [DATA_W-1:0]  ram_reg [REG_NUM];
    logic [REG_NUM-1:0] busy_reg;
    logic [REG_NUM-1:0] busy_next;
    logic [ADDR_W:0]    busy_count_reg;
    logic [ADDR_W:0]    busy_count_next;
    logic               err_reg;
    logic               err_next;

    logic wr_zero;
    logic rsv_zero;
    logic wr_commit;
    logic rsv_ack;
    logic rsv_commit;

    assign wr_zero  = (ZERO_REG != 0) && (bus.wr_addr_i == '0);
    assign rsv_zero = (ZERO_REG != 0) && (bus.rsv_addr_i == '0);

    // A pending register may be re-reserved only in its own writeback cycle.
    assign rsv_ack = bus.rsv_en_i & ~rst_i &
                     (~busy_reg[bus.rsv_addr_i] |
                      (bus.wr_en_i & (bus.wr_addr_i == bus.rsv_addr_i)));

    assign wr_commit  = bus.wr_en_i & ~rst_i & ~wr_zero;
    assign rsv_commit = rsv_ack & ~rsv_zero;

    // New reservation beats the writeback clear on the same register.
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_busy
            assign busy_next[gi] =
                (rsv_commit && (bus.rsv_addr_i == ADDR_W'(gi))) ? 1'b1 :
                (wr_commit  && (bus.wr_addr_i  == ADDR_W'(gi))) ? 1'b0 :
                busy_reg[gi];
        end
    endgenerate

    always_comb begin
        busy_count_next = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy_count_next = busy_count_next + (ADDR_W+1)'(busy_next[i]);
        end
    end

    assign err_next = err_reg | (wr_commit & ~busy_reg[bus.wr_addr_i]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                ram_reg[i] <= '0;
            end
            busy_reg       <= '0;
            busy_count_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (wr_commit) begin
                ram_reg[bus.wr_addr_i] <= bus.wr_data_i;
            end
            busy_reg       <= busy_next;
            busy_count_reg <= busy_count_next;
            err_reg        <= err_next;
        end
    end

    logic [1:0]             rd_en;
    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             rd_ready;

    assign rd_en   = {bus.rd2_en_i, bus.rd1_en_i};
    assign rd_addr = {bus.rd2_addr_i, bus.rd1_addr_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic zero_hit;
            logic byp_hit;
            assign zero_hit = (ZERO_REG != 0) && (rd_addr[gi] == '0);
            assign byp_hit  = bus.wr_en_i && (bus.wr_addr_i == rd_addr[gi]);

            assign rd_ready[gi] = rst_i     ? 1'b0 :
                                  !rd_en[gi] ? 1'b1 :
                                  zero_hit  ? 1'b1 :
                                  byp_hit   ? 1'b1 :
                                  ~busy_reg[rd_addr[gi]];

            assign rd_data[gi] = (rst_i || !rd_en[gi] || zero_hit) ? '0 :
                                 byp_hit                ? bus.wr_data_i :
                                 busy_reg[rd_addr[gi]]  ? '0 :
                                 ram_reg[rd_addr[gi]];
        end
    endgenerate

    assign bus.rd1_data_o   = rd_data[0];
    assign bus.rd1_ready_o  = rd_ready[0];
    assign bus.rd2_data_o   = rd_data[1];
    assign bus.rd2_ready_o  = rd_ready[1];
    assign bus.rsv_ack_o    = rsv_ack;
    assign bus.busy_count_o = busy_count_reg;
    assign bus.err_o        = err_reg;
endmodule

// File: tb/tb_rg_scoreboard.sv
// Drives identical stimulus into a ZERO_REG=0 and a ZERO_REG=1 instance and
// checks both against a register-file/pending-set model through a queue.
module tb_rg_scoreboard;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rg_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    rg_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    rg_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0));
    rg_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1));

    assign bus1.rd1_en_i   = bus0.rd1_en_i;
    assign bus1.rd1_addr_i = bus0.rd1_addr_i;
    assign bus1.rd2_en_i   = bus0.rd2_en_i;
    assign bus1.rd2_addr_i = bus0.rd2_addr_i;
    assign bus1.wr_en_i    = bus0.wr_en_i;
    assign bus1.wr_addr_i  = bus0.wr_addr_i;
    assign bus1.wr_data_i  = bus0.wr_data_i;
    assign bus1.rsv_en_i   = bus0.rsv_en_i;
    assign bus1.rsv_addr_i = bus0.rsv_addr_i;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic          r1;
        logic [DW-1:0] d2;
        logic          r2;
        logic          ack;
        logic [AW:0]   cnt;
        logic          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference state: register contents, set of pending registers, sticky error.
    logic [DW-1:0] mem  [2][N];
    bit            pend [2][N];
    bit            merr [2];

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    function automatic void model_read(input int z, input bit r, input bit en, input int a,
                                       input bit we, input int wa, input logic [DW-1:0] wd,
                                       output logic [DW-1:0] d, output logic rdy);
        if (r) begin d = '0; rdy = 1'b0; end
        else if (!en) begin d = '0; rdy = 1'b1; end
        else if (z == 1 && a == 0) begin d = '0; rdy = 1'b1; end
        else if (we && wa == a) begin d = wd; rdy = 1'b1; end
        else if (pend[z][a]) begin d = '0; rdy = 1'b0; end
        else begin d = mem[z][a]; rdy = 1'b1; end
    endfunction

    task automatic cyc(input bit r, input bit e1, input int a1, input bit e2, input int a2,
                       input bit we, input int wa, input int wd, input bit re, input int ra);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        rst              = r;
        bus0.rd1_en_i    = e1;
        bus0.rd1_addr_i  = a1[AW-1:0];
        bus0.rd2_en_i    = e2;
        bus0.rd2_addr_i  = a2[AW-1:0];
        bus0.wr_en_i     = we;
        bus0.wr_addr_i   = wa[AW-1:0];
        bus0.wr_data_i   = wd[DW-1:0];
        bus0.rsv_en_i    = re;
        bus0.rsv_addr_i  = ra[AW-1:0];
        for (int z = 0; z < 2; z++) begin
            model_read(z, r, e1, a1, we, wa, wd[DW-1:0], e.d1, e.r1);
            model_read(z, r, e2, a2, we, wa, wd[DW-1:0], e.d2, e.r2);
            e.ack = re && !r && (!pend[z][ra] || (we && wa == ra));
            n = 0;
            for (int i = 0; i < N; i++) if (pend[z][i]) n++;
            e.cnt = n[AW:0];
            e.err = merr[z];
            if (z == 0) q0.push_back(e); else q1.push_back(e);
            // advance the reference to the state after this cycle's edge
            if (r) begin
                for (int i = 0; i < N; i++) begin mem[z][i] = '0; pend[z][i] = 0; end
                merr[z] = 0;
            end else begin
                if (we && !(z == 1 && wa == 0)) begin
                    if (!pend[z][wa]) merr[z] = 1;
                    mem[z][wa]  = wd[DW-1:0];
                    pend[z][wa] = 0;
                end
                if (e.ack && !(z == 1 && ra == 0)) pend[z][ra] = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input int z, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d txn%0d got=%h want=%h", nm, z, txn, act, exp);
        end
    endtask

    // Monitor: every cycle carrying a queued expectation is compared at the falling edge.
    initial begin
        exp_t e0, e1;
        forever begin
            @(negedge clk);
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("rd1_data", 0, 32'(bus0.rd1_data_o), 32'(e0.d1));
                chk("rd1_ready", 0, 32'(bus0.rd1_ready_o), 32'(e0.r1));
                chk("rd2_data", 0, 32'(bus0.rd2_data_o), 32'(e0.d2));
                chk("rd2_ready", 0, 32'(bus0.rd2_ready_o), 32'(e0.r2));
                chk("rsv_ack", 0, 32'(bus0.rsv_ack_o), 32'(e0.ack));
                chk("busy_count", 0, 32'(bus0.busy_count_o), 32'(e0.cnt));
                chk("err", 0, 32'(bus0.err_o), 32'(e0.err));
                chk("rd1_data", 1, 32'(bus1.rd1_data_o), 32'(e1.d1));
                chk("rd1_ready", 1, 32'(bus1.rd1_ready_o), 32'(e1.r1));
                chk("rd2_data", 1, 32'(bus1.rd2_data_o), 32'(e1.d2));
                chk("rd2_ready", 1, 32'(bus1.rd2_ready_o), 32'(e1.r2));
                chk("rsv_ack", 1, 32'(bus1.rsv_ack_o), 32'(e1.ack));
                chk("busy_count", 1, 32'(bus1.busy_count_o), 32'(e1.cnt));
                chk("err", 1, 32'(bus1.err_o), 32'(e1.err));
                $display("txn %0d rst=%b rd1=%h/%b rd2=%h/%b ack=%b cnt=%0d err=%b | z: rd1=%h/%b rd2=%h/%b ack=%b cnt=%0d err=%b",
                         txn, rst, bus0.rd1_data_o, bus0.rd1_ready_o, bus0.rd2_data_o, bus0.rd2_ready_o,
                         bus0.rsv_ack_o, bus0.busy_count_o, bus0.err_o,
                         bus1.rd1_data_o, bus1.rd1_ready_o, bus1.rd2_data_o, bus1.rd2_ready_o,
                         bus1.rsv_ack_o, bus1.busy_count_o, bus1.err_o);
                txn++;
            end
        end
    end

    initial begin
        int qleft;
        bus0.rd1_en_i = 0; bus0.rd1_addr_i = '0; bus0.rd2_en_i = 0; bus0.rd2_addr_i = '0;
        bus0.wr_en_i = 0; bus0.wr_addr_i = '0; bus0.wr_data_i = '0;
        bus0.rsv_en_i = 0; bus0.rsv_addr_i = '0;
        for (int z = 0; z < 2; z++) begin
            merr[z] = 0;
            for (int i = 0; i < N; i++) begin mem[z][i] = '0; pend[z][i] = 0; end
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // reset cycle itself, then every register on both ports
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 1, 2);
        for (int i = 0; i < N; i++) cyc(0, 1, i, 1, N-1-i, 0, 0, 0, 0, 0);

        // plain write, later read; bypass of a same-cycle write; unexpected-write error
        cyc(0, 0, 0, 0, 0, 1, 3, 'hBEEF, 0, 0);
        cyc(0, 1, 3, 1, 5, 1, 5, 'h1234, 0, 0);
        cyc(0, 1, 3, 1, 5, 0, 0, 0, 0, 0);

        // reserve, stall, refused re-reserve, writeback releases
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        cyc(0, 1, 2, 0, 0, 0, 0, 0, 1, 2);
        cyc(0, 1, 2, 1, 2, 1, 2, 'h00AA, 0, 0);
        cyc(0, 1, 2, 1, 2, 0, 0, 0, 0, 0);

        // writeback and new reservation of the same register in one cycle
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        cyc(0, 1, 4, 0, 0, 1, 4, 'h5555, 1, 4);
        cyc(0, 1, 4, 1, 4, 0, 0, 0, 1, 4);
        cyc(0, 1, 4, 0, 0, 1, 4, 'h6666, 0, 0);
        cyc(0, 1, 4, 0, 0, 0, 0, 0, 0, 0);

        // register 0 write and reserve together
        cyc(0, 1, 0, 0, 0, 1, 0, 'hFFFF, 1, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

        // several pending registers wiped by a reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        cyc(0, 1, 1, 1, 6, 0, 0, 0, 1, 7);
        cyc(1, 1, 7, 1, 1, 1, 1, 'h0101, 1, 3);
        for (int i = 0; i < N; i++) cyc(0, 1, i, 1, i, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom % 40) == 0,
                ($urandom % 4) != 0, int'($urandom % N),
                ($urandom % 4) != 0, int'($urandom % N),
                ($urandom % 3) == 0, int'($urandom % N), int'($urandom & 32'hFFFF),
                ($urandom % 3) == 0, int'($urandom % N));
        end

        repeat (3) @(posedge clk);
        qleft = q0.size() + q1.size();
        total++;
        if (qleft != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", qleft);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rg_scoreboard.md
# rg_scoreboard

Parametrised successor to the 2-read/1-write register file: same read-port bypass behaviour, plus configurable data width and depth, synchronous clear, an optional hard-wired zero register, and a per-register pending (busy) scoreboard. The scoreboard lets the decode stage reserve a destination register at issue and release it at writeback. Reads of a pending register are reported not-ready, so the pipeline controller stalls on RAW hazards without its own hazard table. The block sits between decode (reads, reserves) and writeback (writes).

## Interface
- DATA_W, 16: register data width.
- ADDR_W, 3: register address width; REG_NUM = 2**ADDR_W registers (localparam).
- ZERO_REG, 0: 1 = register 0 always reads 0, never busy, writes ignored.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rd1_en_i / rd2_en_i  in  1  read-port enable.
- rd1_addr_i / rd2_addr_i  in  ADDR_W  read address.
- rd1_data_o / rd2_data_o  out  DATA_W  read data (combinational).
- rd1_ready_o / rd2_ready_o  out  1  read data valid, no hazard (combinational).
- wr_en_i  in  1  writeback strobe.
- wr_addr_i  in  ADDR_W  writeback address.
- wr_data_i  in  DATA_W  writeback data.
- rsv_en_i  in  1  reserve request from issue.
- rsv_addr_i  in  ADDR_W  register to mark pending.
- rsv_ack_o  out  1  reserve accepted this cycle (combinational).
- busy_count_o  out  ADDR_W+1  number of pending registers (registered).
- err_o  out  1  sticky: write to a register that was not pending.

## Operation
- State: RAM[REG_NUM] of DATA_W, busy[REG_NUM], busy_count, err.
- Read port N (identical, independent):
  - rst_i=1: data 0, ready 0.
  - en=0: data 0, ready 1.
  - ZERO_REG=1 and addr=0: data 0, ready 1.
  - wr_en_i=1 and wr_addr_i=addr: data wr_data_i, ready 1 (bypass; takes priority over busy).
  - busy[addr]=1: data 0, ready 0.
  - else: data RAM[addr], ready 1.
- Reserve: rsv_ack_o = rsv_en_i & !rst_i & (!busy[rsv_addr_i] | (wr_en_i & wr_addr_i==rsv_addr_i)). WAW on a still-pending register is refused (ack 0); the requester retries. Accepted reserve sets busy[rsv_addr_i] at the edge. ZERO_REG=1, addr 0: ack 1, busy not set.
- Write (wr_en_i & !rst_i): RAM[wr_addr_i] <= wr_data_i, busy cleared. If busy was 0 (and not zero-reg case), err set, data still written. ZERO_REG=1, addr 0: ignored, no error.
- Same-cycle write and accepted reserve to same register: RAM written, busy ends 1 (new reservation wins), count unchanged.
- busy_count: +1 per accepted reserve that sets a bit, -1 per write clearing a set bit, net in one cycle; never exceeds REG_NUM.

## Timing
- Reset (rst_i high at edge): all RAM = 0, busy = 0, busy_count_o = 0, err_o = 0. Write and reserve inputs ignored that cycle. Reset mid-stall discards all reservations.
- Read latency 0 (combinational from address/enable/write-port inputs). Write visible via bypass in same cycle, via RAM from next cycle.
- Reserve: ack same cycle. Reserved register reads not-ready from the following cycle until the writeback cycle (ready via bypass) and after.
- busy_count_o, err_o change only on clock edges.
- No combinational path from rdN outputs to any input. rsv_ack_o depends on rsv_*, wr_*, rst_i.

## Test plan
- Reset then read all 8 regs on both ports -> data 0x0000, ready 1, busy_count_o 0, err_o 0.
- Write r3=0xBEEF, next cycle read r3 on port 1 -> 0xBEEF; same-cycle read of r5 while writing r5=0x1234 -> 0x1234 via bypass; err_o goes 1 (r5 not pending).
- Reserve r2 (ack 1), next cycle read r2 -> ready 0, data 0, busy_count_o 1. Re-reserve r2 -> ack 0. Write r2=0x00AA: that cycle read ready 1 with 0x00AA; next cycle busy_count_o 0, err_o 0.
- Same cycle: write r4=0x5555 (r4 pending) and reserve r4 -> ack 1; next cycle RAM r4 = 0x5555, r4 still busy, count unchanged.
- ZERO_REG=1: write r0=0xFFFF, reserve r0 -> ack 1; read r0 -> 0x0000 ready 1, busy_count_o 0, err_o 0.
- Reserve r1,r6,r7 across cycles (count 3), assert rst_i one cycle -> count 0, all reads ready with 0x0000, reserve during reset -> ack 0.
